// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises one SD-card command frame onto the CMD line.
//
// Frame (48 bits, MSB first): start 0, transmission 1, cmd_index[5:0],
// argument[31:0], CRC7[6:0], end 1.  Each bit is held for DIV clocks.
// CRC7 (x^7 + x^3 + 1, init 0) is accumulated serially while the first
// 40 bits go out, then shifted out directly, so no frame-wide CRC logic.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   start       send request, sampled only in IDLE
//   cmd_index   6-bit command index, latched when start is accepted
//   argument    32-bit argument, latched when start is accepted
//   sd_cmd_out  serial CMD-line data (idles high)
//   sd_cmd_oe   CMD-line output enable, high only while a frame is driven
//   busy        high while a frame is in progress
//   done        one-cycle pulse in the cycle after the end bit
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line released (oe=0, out=1); waiting for start
// SEND  | driving the 48 frame bits, DIV clocks per bit

module sd_cmd_tx #(
    parameter int DIV = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div_cnt;
    logic [5:0]  r_bit_cnt;
    logic [39:0] r_frame;
    logic [6:0]  r_crc;
    logic        r_done;

    logic w_accept;
    logic w_bit_end;
    logic w_last_bit;
    logic w_crc_fb;
    logic w_bit;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_bit_end  = (r_state == SEND) && (r_div_cnt == DIV_LAST);
    assign w_last_bit = (r_bit_cnt == 6'd47);
    assign w_crc_fb   = r_frame[39] ^ r_crc[6];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = SEND;
            SEND: if (w_bit_end && w_last_bit) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt <= 8'd0;
            r_bit_cnt <= 6'd0;
            r_frame   <= 40'd0;
            r_crc     <= 7'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_bit_end && w_last_bit;
            if (w_accept) begin
                r_frame   <= {2'b01, cmd_index, argument};
                r_crc     <= 7'd0;
                r_div_cnt <= 8'd0;
                r_bit_cnt <= 6'd0;
            end else if (r_state == SEND) begin
                if (w_bit_end) begin
                    r_div_cnt <= 8'd0;
                    r_bit_cnt <= w_last_bit ? 6'd0 : r_bit_cnt + 6'd1;
                    if (r_bit_cnt < 6'd40) begin
                        // Update CRC with the bit just sent, then advance.
                        r_frame <= {r_frame[38:0], 1'b0};
                        r_crc   <= {r_crc[5:3], r_crc[2] ^ w_crc_fb,
                                    r_crc[1:0], w_crc_fb};
                    end else if (r_bit_cnt < 6'd47) begin
                        r_crc <= {r_crc[5:0], 1'b0};
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_bit = 1'b1;
        if (r_bit_cnt < 6'd40) begin
            w_bit = r_frame[39];
        end else if (r_bit_cnt < 6'd47) begin
            w_bit = r_crc[6];
        end
    end

    assign sd_cmd_out = (r_state == SEND) ? w_bit : 1'b1;
    assign sd_cmd_oe  = (r_state == SEND);
    assign busy       = (r_state == SEND);
    assign done       = r_done;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Testbench for sd_cmd_tx: instance A uses DIV=2, instance B uses DIV=1.
// Stimulus pushes expected frames into a queue; a monitor reconstructs
// each frame from the CMD line and checks it against the queue.

module tb_sd_cmd_tx;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD17 = 48'h51_0000_0000_55;

    typedef struct packed {
        logic [47:0] fr;
        logic        cg;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic [5:0]  idx0 = 6'd0, idx1 = 6'd0;
    logic [31:0] arg0 = 32'd0, arg1 = 32'd0;
    logic [1:0]  out_v, oe_v, busy_v, done_v;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   fin = 1'b0;

    always #5 clk = ~clk;

    sd_cmd_tx #(.DIV(DIV_A)) u_dut_a (
        .clock(clk), .resetn(resetn), .start(start_v[0]),
        .cmd_index(idx0), .argument(arg0),
        .sd_cmd_out(out_v[0]), .sd_cmd_oe(oe_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    sd_cmd_tx #(.DIV(DIV_B)) u_dut_b (
        .clock(clk), .resetn(resetn), .start(start_v[1]),
        .cmd_index(idx1), .argument(arg1),
        .sd_cmd_out(out_v[1]), .sd_cmd_oe(oe_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    // ---------------- monitor / scoreboard ----------------
    logic [95:0] samp [2];
    int          len [2];
    int          gap [2];
    int          cur_gap [2];
    logic [1:0]  prev_oe = 2'b00;
    bit          rst_seen = 1'b0;
    bit          fin_chk = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    always begin
        @(negedge clk or negedge resetn);
        #1;
        if (fin && !fin_chk) begin
            chk(q.size() == 0, "queue_empty", 64'(q.size()), 64'd0);
            fin_chk = 1'b1;
        end
        if (!resetn) begin
            if (!rst_seen) begin
                for (int g = 0; g < 2; g++) begin
                    chk(oe_v[g] == 1'b0 && out_v[g] == 1'b1 && busy_v[g] == 1'b0
                        && done_v[g] == 1'b0, "reset_outputs",
                        {60'd0, oe_v[g], out_v[g], busy_v[g], done_v[g]}, 64'b0100);
                    len[g] = 0;
                    gap[g] = 0;
                end
                prev_oe = 2'b00;
                rst_seen = 1'b1;
            end
        end else begin
            rst_seen = 1'b0;
            for (int g = 0; g < 2; g++) begin
                int   dv;
                logic exp_done;
                dv = (g == 0) ? DIV_A : DIV_B;
                exp_done = prev_oe[g] && !oe_v[g];
                chk(busy_v[g] == oe_v[g] && done_v[g] == exp_done && (oe_v[g] || out_v[g]),
                    "cycle_status",
                    {60'd0, busy_v[g], oe_v[g], done_v[g], out_v[g]},
                    {60'd0, oe_v[g], oe_v[g], exp_done, (oe_v[g] ? out_v[g] : 1'b1)});
                if (oe_v[g]) begin
                    if (!prev_oe[g]) begin
                        cur_gap[g] = gap[g];
                        len[g] = 0;
                    end
                    if (len[g] < 96) samp[g][len[g]] = out_v[g];
                    len[g]++;
                    gap[g] = 0;
                end else begin
                    if (prev_oe[g]) begin
                        if (q.size() == 0) begin
                            chk(1'b0, "unexpected_frame", 64'(g), 64'd0);
                        end else begin
                            exp_t        e;
                            logic [47:0] fr;
                            bit          hold_ok;
                            e = q.pop_front();
                            chk(len[g] == 48 * dv, "frame_length", 64'(len[g]), 64'(48 * dv));
                            hold_ok = 1'b1;
                            fr = '0;
                            if (len[g] == 48 * dv) begin
                                for (int k = 0; k < 48; k++) fr[47 - k] = samp[g][k * dv];
                                for (int i = 0; i < 48 * dv; i++)
                                    if (samp[g][i] != samp[g][(i / dv) * dv]) hold_ok = 1'b0;
                            end
                            chk(hold_ok, "bit_hold", 64'(hold_ok), 64'd1);
                            chk(fr == e.fr, "frame_value", 64'(fr), 64'(e.fr));
                            if (e.cg) chk(cur_gap[g] == 1, "idle_gap", 64'(cur_gap[g]), 64'd1);
                        end
                    end
                    gap[g]++;
                end
                prev_oe[g] = oe_v[g];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input int g, input logic [5:0] idx, input logic [31:0] arg,
                      input logic [47:0] fr, input bit cg, input bit push);
        exp_t e;
        if (push) begin
            e.fr = fr;
            e.cg = cg;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g == 0) begin
            idx0 = idx;
            arg0 = arg;
        end else begin
            idx1 = idx;
            arg1 = arg;
        end
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        bit found;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(posedge clk);
            #1;
            if (done_v[g]) found = 1'b1;
        end
        if (!found) begin
            $display("FAIL done_timeout: instance %0d no done within %0d cycles", g, budget);
            $fatal(1, "timeout");
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // CMD0 and CMD8, DIV=2
        go(0, 6'd0, 32'h0000_0000, F_CMD0, 1'b0, 1'b1);
        wait_done(0, 300);
        go(0, 6'd8, 32'h0000_01AA, F_CMD8, 1'b0, 1'b1);
        wait_done(0, 300);

        // start and inputs changed mid-frame must not disturb the frame
        go(0, 6'd8, 32'h0000_01AA, F_CMD8, 1'b0, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        idx0 = 6'h3F;
        arg0 = 32'hDEAD_BEEF;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 300);

        // reset at bit 20: go returns in the first driven cycle (bit 0)
        go(0, 6'd0, 32'h0000_0000, F_CMD0, 1'b0, 1'b0);
        repeat (20 * DIV_A) @(posedge clk);
        #2;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        go(0, 6'd8, 32'h0000_01AA, F_CMD8, 1'b0, 1'b1);
        wait_done(0, 300);

        // start held high: two back-to-back frames, one idle cycle apart
        begin
            exp_t e;
            e.fr = F_CMD0; e.cg = 1'b0; q.push_back(e);
            e.fr = F_CMD0; e.cg = 1'b1; q.push_back(e);
        end
        @(posedge clk);
        #1;
        idx0 = 6'd0;
        arg0 = 32'd0;
        start_v[0] = 1'b1;
        wait_done(0, 300);
        repeat (10) @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 300);

        // CMD17 and CMD8 on the DIV=1 instance
        go(1, 6'd17, 32'h0000_0000, F_CMD17, 1'b0, 1'b1);
        wait_done(1, 200);
        go(1, 6'd8, 32'h0000_01AA, F_CMD8, 1'b0, 1'b1);
        wait_done(1, 200);

        repeat (5) @(posedge clk);
        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
